// File: rtl/j1_boot_pkg.sv
// Shared definitions for the j1 boot loader: state encoding, magic byte
// and default program RAM address width.
package j1_boot_pkg;

   localparam int         ADDR_W_DEF = 14;
   localparam logic [7:0] BOOT_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      WAIT_MAGIC = 3'd0,
      LEN_HI     = 3'd1,
      LEN_LO     = 3'd2,
      DATA       = 3'd3,
      CSUM       = 3'd4,
      DONE       = 3'd5,
      ERR        = 3'd6
   } boot_state_e;

endpackage

// File: rtl/j1_boot_timeout.sv
// Loadable down-counter; expired_o flags a count of zero while enabled and
// no reload is requested in the same cycle.
module j1_boot_timeout #(
   parameter int W = 20
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/j1_boot_ctrl.sv
// Byte-stream boot loader for the j1 core: magic, big-endian word count,
// MSB-first 32-bit words, XOR checksum; holds the core in reset until done.
//
// Handshake: a byte transfers on any rising edge where rx_valid and rx_ready
// are both 1; rx_ready depends only on the current state and the source may
// present a new byte every cycle.
module j1_boot_ctrl
   import j1_boot_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = 1000000
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_i,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              cpu_rst_o,
   output logic              boot_done,
   output logic              boot_err,
   output boot_state_e       state_o
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   boot_state_e       state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [7:0]        csum_q, csum_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [15:0]       widx_q, widx_d;
   logic [23:0]       shift_q, shift_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              boot_done_q, boot_done_d;
   logic              boot_err_q, boot_err_d;

   logic              accept;
   logic              tmo_en;
   logic              tmo_exp;
   logic [15:0]       n_word;
   logic              len_bad;
   logic              last_word;

   assign rx_ready  = (state_q != DONE);
   assign accept    = rx_valid && rx_ready;
   assign tmo_en    = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CSUM);
   assign n_word    = {len_q[15:8], rx_data};
   assign len_bad   = (n_word == 16'd0) || (32'(n_word) > (32'd1 << ADDR_W));
   assign last_word = (widx_q == (len_q - 16'd1));

   // Reloaded on every accepted byte and while idle, so each active state
   // starts with a full inter-byte budget.
   j1_boot_timeout #(
      .W(TW)
   ) u_timeout (
      .clk_i      (sys_clk_i),
      .rst_i      (sys_rst_i),
      .load_i     (accept || !tmo_en),
      .load_val_i (TW'(TIMEOUT - 1)),
      .en_i       (tmo_en),
      .expired_o  (tmo_exp)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      csum_d      = csum_q;
      bidx_d      = bidx_q;
      widx_d      = widx_q;
      shift_d     = shift_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      boot_err_d  = boot_err_q;

      case (state_q)
         WAIT_MAGIC, ERR: begin
            state_d = WAIT_MAGIC;
            if (accept && (rx_data == BOOT_MAGIC)) begin
               state_d    = LEN_HI;
               boot_err_d = 1'b0;
               csum_d     = 8'd0;
               bidx_d     = 2'd0;
               widx_d     = 16'd0;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d   = {rx_data, len_q[7:0]};
               state_d = LEN_LO;
            end else if (tmo_exp) begin
               state_d = ERR;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d   = n_word;
               state_d = len_bad ? ERR : DATA;
            end else if (tmo_exp) begin
               state_d = ERR;
            end
         end
         DATA: begin
            if (accept) begin
               csum_d  = csum_q ^ rx_data;
               bidx_d  = bidx_q + 2'd1;
               shift_d = {shift_q[15:0], rx_data};
               if (bidx_q == 2'd3) begin
                  ram_we_d    = 1'b1;
                  ram_addr_d  = widx_q[ADDR_W-1:0];
                  ram_wdata_d = {shift_q, rx_data};
                  widx_d      = widx_q + 16'd1;
                  if (last_word) begin
                     state_d = CSUM;
                  end
               end
            end else if (tmo_exp) begin
               state_d = ERR;
            end
         end
         CSUM: begin
            if (accept) begin
               state_d = (rx_data == csum_q) ? DONE : ERR;
            end else if (tmo_exp) begin
               state_d = ERR;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = WAIT_MAGIC;
         end
      endcase

      if (state_d == ERR) begin
         boot_err_d = 1'b1;
      end
      cpu_rst_d   = (state_d != DONE);
      boot_done_d = (state_d == DONE);
   end

   // Reset wins over a write computed in the same cycle, cancelling it.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q     <= WAIT_MAGIC;
         len_q       <= 16'd0;
         csum_q      <= 8'd0;
         bidx_q      <= 2'd0;
         widx_q      <= 16'd0;
         shift_q     <= 24'd0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'd0;
         cpu_rst_q   <= 1'b1;
         boot_done_q <= 1'b0;
         boot_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         csum_q      <= csum_d;
         bidx_q      <= bidx_d;
         widx_q      <= widx_d;
         shift_q     <= shift_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_rst_q   <= cpu_rst_d;
         boot_done_q <= boot_done_d;
         boot_err_q  <= boot_err_d;
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_rst_o = cpu_rst_q;
   assign boot_done = boot_done_q;
   assign boot_err  = boot_err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// Directed bench for j1_boot_ctrl: good/bad images, junk and bad lengths,
// timeout, reset mid-word and DONE lock-out.
module tb_j1_boot_ctrl;
   import j1_boot_pkg::*;

   localparam int ADDR_W  = 14;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              cpu_rst;
   logic              boot_done;
   logic              boot_err;
   boot_state_e       state;

   int n_vec = 0;
   int n_err = 0;

   logic [ADDR_W+31:0] exp_q[$];
   logic [7:0]         img[8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                  8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0]         good_cs;

   j1_boot_ctrl #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .cpu_rst_o (cpu_rst),
      .boot_done (boot_done),
      .boot_err  (boot_err),
      .state_o   (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change 1ns after the active edge
   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst      = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   task automatic send_image(input logic [7:0] cs);
      exp_q.push_back({14'd0, 32'h11223344});
      exp_q.push_back({14'd1, 32'h55667788});
      send(8'hA5); send(8'h00); send(8'h02);
      for (int i = 0; i < 8; i++) send(img[i]);
      send(cs);
   endtask

   // scoreboard: every ram_we must match the head of the expected queue
   always @(negedge clk) begin
      if (ram_we) begin
         if (exp_q.size() > 0) begin
            check_eq("ram_write", 64'({ram_addr, ram_wdata}), 64'(exp_q.pop_front()));
         end else begin
            check_eq("spurious_we", 64'(ram_we), 64'd0);
         end
      end
   end

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      good_cs  = 8'h00;
      for (int i = 0; i < 8; i++) good_cs = good_cs ^ img[i];
      do_reset();

      // reset values
      check_eq("rst_state", 64'(state), 64'(WAIT_MAGIC));
      check_eq("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check_eq("rst_done", 64'(boot_done), 64'd0);
      check_eq("rst_err", 64'(boot_err), 64'd0);
      check_eq("rst_we", 64'(ram_we), 64'd0);
      check_eq("rst_addr", 64'(ram_addr), 64'd0);
      check_eq("rst_wdata", 64'(ram_wdata), 64'd0);
      check_eq("rst_ready", 64'(rx_ready), 64'd1);

      // bad checksum
      send_image(8'h01);
      check_eq("badcs_state", 64'(state), 64'(ERR));
      check_eq("badcs_err", 64'(boot_err), 64'd1);
      check_eq("badcs_cpu_rst", 64'(cpu_rst), 64'd1);
      check_eq("badcs_done", 64'(boot_done), 64'd0);
      check_eq("err_ready", 64'(rx_ready), 64'd1);
      idle(1);
      check_eq("err_to_wait", 64'(state), 64'(WAIT_MAGIC));
      check_eq("err_sticky", 64'(boot_err), 64'd1);

      // good restream
      send_image(good_cs);
      check_eq("good_state", 64'(state), 64'(DONE));
      check_eq("good_cpu_rst", 64'(cpu_rst), 64'd0);
      check_eq("good_done", 64'(boot_done), 64'd1);
      check_eq("good_err_clr", 64'(boot_err), 64'd0);

      // DONE ignores further bytes
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("done_ready", 64'(rx_ready), 64'd0);
         check_eq("done_cpu_rst", 64'(cpu_rst), 64'd0);
         check_eq("done_we", 64'(ram_we), 64'd0);
      end
      check_eq("done_state", 64'(state), 64'(DONE));
      do_reset();

      // junk then N=0
      send(8'h00); send(8'hFF);
      check_eq("junk_state", 64'(state), 64'(WAIT_MAGIC));
      send(8'hA5); send(8'h00); send(8'h00);
      check_eq("n0_state", 64'(state), 64'(ERR));
      check_eq("n0_err", 64'(boot_err), 64'd1);
      idle(2);

      // N just over capacity, then exactly capacity
      send(8'hA5); send(8'h40); send(8'h01);
      check_eq("nbig_state", 64'(state), 64'(ERR));
      idle(1);
      send(8'hA5); send(8'h40); send(8'h00);
      check_eq("nmax_state", 64'(state), 64'(DATA));
      check_eq("nmax_err", 64'(boot_err), 64'd0);
      idle(TIMEOUT + 2);

      // timeout after two data bytes
      send(8'hA5); send(8'h00); send(8'h01); send(8'h11); send(8'h22);
      idle(TIMEOUT - 1);
      check_eq("tmo_early_state", 64'(state), 64'(DATA));
      check_eq("tmo_early_err", 64'(boot_err), 64'd0);
      idle(1);
      check_eq("tmo_state", 64'(state), 64'(ERR));
      check_eq("tmo_err", 64'(boot_err), 64'd1);
      idle(2);

      // reset on the 4th data byte cancels the write
      send(8'hA5); send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
      rst = 1'b1;
      send(8'h44);
      rst = 1'b0;
      rx_valid = 1'b0;
      check_eq("rstmid_we", 64'(ram_we), 64'd0);
      check_eq("rstmid_state", 64'(state), 64'(WAIT_MAGIC));
      check_eq("rstmid_cpu_rst", 64'(cpu_rst), 64'd1);
      check_eq("rstmid_addr", 64'(ram_addr), 64'd0);
      check_eq("rstmid_wdata", 64'(ram_wdata), 64'd0);
      check_eq("rstmid_done", 64'(boot_done), 64'd0);
      check_eq("rstmid_err", 64'(boot_err), 64'd0);
      idle(3);

      check_eq("writes_pending", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
